multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the CPU datapath. It replaces single-cycle opcode decoding with a sequenced FETCH/DECODE/EXEC/MEM/WB flow, a ready/valid-style memory wait, a memory timeout, illegal-opcode detection and a retired-instruction counter. It drives the datapath muxes, the register file, the PC and the instruction/data memory port.

---
 rtl/multicycle_control_unit.sv | 99 +++++++++
 tb/tb_multicycle_control_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait, timeout and retire counter
module multicycle_control_unit #(
   parameter int OPCODE_W    = 3,
   parameter int COUNT_W     = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [OPCODE_W-1:0] OPCODE,
   input  logic                Zero,
   input  logic                MemReady,
   output logic                IRWrite,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                PCWrite,
   output logic                PCSrc,
   output logic                RegDst,
   output logic                RegWrite,
   output logic                MemToReg,
   output logic                ALUSrc,
   output logic [1:0]          ALUOp,
   output logic                Illegal,
   output logic                MemError,
   output logic [COUNT_W-1:0]  InstrCount
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [2:0] INIT = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5;
   logic [2:0] state, nextState, opReg;
   logic [WAIT_W-1:0] waitCnt;
   logic isR, isImm, isLw, isSw, isBne, badOp, memState, timeout, retire;
   assign isR = opReg == 3'd0;
   assign isImm = opReg inside {3'd1, 3'd2, 3'd3, 3'd4};
   assign isLw = opReg == 3'd5;
   assign isSw = opReg == 3'd6;
   assign isBne = opReg == 3'd7;
   assign badOp = (OPCODE >> 3) != '0;
   assign memState = state == FETCH || state == MEM;
   assign timeout = memState && !MemReady && waitCnt == WAIT_W'(MEM_TIMEOUT);
   assign retire = state == WB || (state == EXEC && isBne) || (state == MEM && MemReady && isSw);
   assign Illegal = state == DECODE && badOp;
   assign MemError = timeout;
   // next-state sequencing; a memory timeout falls back to FETCH without retiring
   always_comb begin
      nextState = INIT;
      case (state)
         INIT:    nextState = FETCH;
         FETCH:   nextState = MemReady ? DECODE : FETCH;
         DECODE:  nextState = badOp ? FETCH : EXEC;
         EXEC:    nextState = isBne ? FETCH : (isLw || isSw) ? MEM : WB;
         MEM:     nextState = MemReady ? (isLw ? WB : FETCH) : timeout ? FETCH : MEM;
         WB:      nextState = FETCH;
         default: nextState = INIT;
      endcase
   end
   // datapath controls decoded from state and latched opcode; PCWrite also sees MemReady/Zero
   always_comb begin
      {IRWrite, IorD, MemRead, MemWrite, PCWrite, PCSrc, RegDst, RegWrite, MemToReg, ALUSrc, ALUOp} = '0;
      case (state)
         FETCH: begin
            IRWrite = 1'b1;
            MemRead = 1'b1;
            PCWrite = MemReady;
         end
         EXEC: begin
            ALUSrc = !(isR || isBne);
            ALUOp = isR ? 2'b10 : isImm ? 2'b11 : isBne ? 2'b01 : 2'b00;
            PCSrc = isBne;
            PCWrite = isBne && !Zero;
         end
         MEM: begin
            IorD = 1'b1;
            MemRead = isLw;
            MemWrite = isSw;
            ALUSrc = 1'b1;
         end
         WB: begin
            RegWrite = 1'b1;
            RegDst = isR;
            MemToReg = isLw;
         end
         default: ;
      endcase
   end
   // state, opcode latch, memory wait counter and retired-instruction counter
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= INIT;
         opReg <= '0;
         waitCnt <= '0;
         InstrCount <= '0;
      end else begin
         state <= nextState;
         if (state == DECODE) opReg <= OPCODE[2:0];
         waitCnt <= (memState && !MemReady && !timeout) ? waitCnt + 1'b1 : '0;
         if (retire) InstrCount <= InstrCount + 1'b1;
      end
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed vector table plus timeout, wrap and reset sequences
module tb_multicycle_control_unit;
   logic Clock = 1'b0, Reset = 1'b1, Zero = 1'b0, MemReady = 1'b1;
   logic [3:0] OPCODE = '0;
   logic [13:0] outs, outs2;
   logic [15:0] count1;
   logic [1:0] count2;
   int total = 0, bad = 0, ec = 0;
   localparam logic [13:0] IRW = 14'h2000, IOD = 14'h1000, MRD = 14'h0800, MWR = 14'h0400;
   localparam logic [13:0] PCW = 14'h0200, PCS = 14'h0100, RDS = 14'h0080, RGW = 14'h0040;
   localparam logic [13:0] M2R = 14'h0020, ASR = 14'h0010, AO1 = 14'h0008, AO0 = 14'h0004;
   localparam logic [13:0] ILL = 14'h0002, MER = 14'h0001;
   localparam logic [13:0] F1 = IRW | MRD | PCW, F0 = IRW | MRD;
   localparam logic [13:0] EXR = AO1, EXI = ASR | AO1 | AO0, EXM = ASR, EXB0 = PCW | PCS | AO0, EXB1 = PCS | AO0;
   localparam logic [13:0] MLW = IOD | MRD | ASR, MSW = IOD | MWR | ASR;
   localparam logic [13:0] WBR = RDS | RGW, WBI = RGW, WBL = RGW | M2R;
   typedef struct {
      logic [3:0]  op;
      logic        z;
      logic        r;
      logic [13:0] e;
      int          c;
   } vec_t;
   vec_t vecs[$];

   multicycle_control_unit #(.OPCODE_W(4), .COUNT_W(16), .MEM_TIMEOUT(15)) dut (
      .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .Zero(Zero), .MemReady(MemReady),
      .IRWrite(outs[13]), .IorD(outs[12]), .MemRead(outs[11]), .MemWrite(outs[10]),
      .PCWrite(outs[9]), .PCSrc(outs[8]), .RegDst(outs[7]), .RegWrite(outs[6]),
      .MemToReg(outs[5]), .ALUSrc(outs[4]), .ALUOp(outs[3:2]), .Illegal(outs[1]),
      .MemError(outs[0]), .InstrCount(count1)
   );

   multicycle_control_unit #(.OPCODE_W(4), .COUNT_W(2), .MEM_TIMEOUT(15)) dut2 (
      .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .Zero(Zero), .MemReady(MemReady),
      .IRWrite(outs2[13]), .IorD(outs2[12]), .MemRead(outs2[11]), .MemWrite(outs2[10]),
      .PCWrite(outs2[9]), .PCSrc(outs2[8]), .RegDst(outs2[7]), .RegWrite(outs2[6]),
      .MemToReg(outs2[5]), .ALUSrc(outs2[4]), .ALUOp(outs2[3:2]), .Illegal(outs2[1]),
      .MemError(outs2[0]), .InstrCount(count2)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] op, input logic z, input logic r, input logic [13:0] e, input int c);
      @(negedge Clock);
      OPCODE = op;
      Zero = z;
      MemReady = r;
      #1;
      chk("outs", int'(outs), int'(e));
      chk("outs_w2", int'(outs2), int'(e));
      chk("count", int'(count1), c);
      chk("count_w2", int'(count2), c % 4);
   endtask

   task automatic rstChk();
      chk("rst_outs", int'(outs), 0);
      chk("rst_outs_w2", int'(outs2), 0);
      chk("rst_count", int'(count1), 0);
      chk("rst_count_w2", int'(count2), 0);
   endtask

   function automatic void add(input logic [3:0] op, input logic z, input logic r, input logic [13:0] e);
      vecs.push_back('{op, z, r, e, ec});
   endfunction

   initial begin
      #3;
      rstChk();
      add(0, 0, 1, 0);
      add(0, 0, 1, F1); add(3, 0, 1, 0); add(3, 0, 1, EXI); add(3, 0, 1, WBI); ec++;
      add(0, 0, 1, F1); add(5, 0, 1, 0); add(5, 0, 1, EXM);
      add(5, 0, 0, MLW); add(5, 0, 0, MLW); add(5, 0, 0, MLW); add(5, 0, 1, MLW); add(5, 0, 1, WBL); ec++;
      add(0, 0, 1, F1); add(7, 0, 1, 0); add(7, 0, 1, EXB0); ec++;
      add(0, 0, 1, F1); add(7, 0, 1, 0); add(7, 1, 1, EXB1); ec++;
      add(0, 0, 1, F1); add(4'b1010, 0, 1, ILL);
      add(0, 0, 1, F1); add(0, 0, 1, 0); add(0, 0, 1, EXR); add(0, 0, 1, WBR); ec++;
      add(0, 0, 1, F1); add(1, 0, 1, 0); add(1, 0, 1, EXI); add(1, 0, 1, WBI); ec++;
      add(0, 0, 1, F1); add(4, 0, 1, 0); add(4, 0, 1, EXI); add(4, 0, 1, WBI); ec++;
      add(0, 0, 1, F1); add(6, 0, 1, 0); add(6, 0, 1, EXM); add(6, 0, 1, MSW); ec++;
      add(0, 0, 0, F0); add(0, 0, 0, F0); add(0, 0, 1, F1); add(0, 0, 1, 0); add(0, 0, 1, EXR); add(0, 0, 1, WBR); ec++;
      @(posedge Clock);
      #2 Reset = 1'b0;
      foreach (vecs[i]) step(vecs[i].op, vecs[i].z, vecs[i].r, vecs[i].e, vecs[i].c);
      step(0, 0, 1, F1, 9); step(6, 0, 1, 0, 9); step(6, 0, 1, EXM, 9);
      for (int i = 0; i < 15; i++) step(6, 0, 0, MSW, 9);
      step(6, 0, 0, MSW | MER, 9);
      step(0, 0, 1, F1, 9); step(6, 0, 1, 0, 9); step(6, 0, 1, EXM, 9);
      for (int i = 0; i < 15; i++) step(6, 0, 0, MSW, 9);
      step(6, 0, 1, MSW, 9);
      for (int i = 0; i < 15; i++) step(0, 0, 0, F0, 10);
      step(0, 0, 0, F0 | MER, 10);
      step(0, 0, 1, F1, 10); step(0, 0, 1, 0, 10);
      #2 Reset = 1'b1;
      #1 rstChk();
      @(posedge Clock);
      #2 Reset = 1'b0;
      step(0, 0, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 1, F1, k); step(0, 0, 1, 0, k); step(0, 0, 1, EXR, k); step(0, 0, 1, WBR, k);
      end
      step(0, 0, 1, F1, 5); step(0, 0, 1, 0, 5); step(0, 0, 1, EXR, 5); step(0, 0, 1, WBR, 5);
      #1 Reset = 1'b1;
      #1 rstChk();
      @(posedge Clock);
      #2 Reset = 1'b0;
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, F1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
